// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared types, default widths and helpers for the LDPC decoder datapath
package ldpc_pkg;
    typedef enum logic {ACCUM, EMIT} state_t;
    localparam int DEF_W = 21;
    localparam int DEF_DEG = 8;
    localparam logic [DEF_W-2:0] MAG_MAX = '1;
    function automatic int cnt_w(input int deg);
        return deg < 2 ? 1 : $clog2(deg);
    endfunction
endpackage

// File: rtl/llr_abs_sat.sv
// llr_abs_sat: split a two's-complement LLR into sign and saturated magnitude
module llr_abs_sat #(
    parameter int W = 21
) (
    input  logic [W-1:0] llr,
    output logic         sgn,
    output logic [W-2:0] mag
);
    logic [W-1:0] neg;
    assign neg = -llr;
    assign sgn = llr[W-1];
    // the most negative code negates onto itself, so its msb flags saturation
    assign mag = !llr[W-1] ? llr[W-2:0] : neg[W-1] ? '1 : neg[W-2:0];
endmodule

// File: rtl/minsum_check_node.sv
// minsum_check_node: serial min-sum / offset-min-sum LDPC check node of degree DEG
module minsum_check_node import ldpc_pkg::*; #(
    parameter int W = DEF_W,
    parameter int DEG = DEF_DEG,
    parameter int OFFSET = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last
);
    localparam int CW = cnt_w(DEG);
    localparam logic [CW-1:0] LAST = CW'(DEG - 1);
    localparam logic [W-2:0] OFF = (W-1)'(OFFSET);

    state_t         state, state_d;
    logic [CW-1:0]  cnt, idx1;
    logic [W-2:0]   min1, min2, mag, sel, adj;
    logic [DEG-1:0] sgn;
    logic           parity, mode_r, s, in_fire, out_fire, at_last;

    llr_abs_sat #(.W(W)) u_abs (.llr(in_data), .sgn(s), .mag(mag));

    assign in_ready  = state == ACCUM;
    assign out_valid = state == EMIT;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_ready && out_valid;
    assign at_last   = cnt == LAST;

    // next state: leave ACCUM on the last accepted edge, leave EMIT on the last delivered edge
    always_comb begin
        state_d = (in_fire && at_last) ? EMIT : (out_fire && at_last) ? ACCUM : state;
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_d;
    end

    // shared edge counter plus two-minimum, sign and parity accumulation; cleared at block end
    always_ff @(posedge clk) begin
        if (!rst_n || (out_fire && at_last)) begin
            cnt    <= '0;
            min1   <= '1;
            min2   <= '1;
            idx1   <= '0;
            parity <= 1'b0;
            sgn    <= '0;
            mode_r <= 1'b0;
        end else if (in_fire) begin
            cnt         <= at_last ? '0 : cnt + 1'b1;
            sgn[cnt]    <= s;
            parity      <= parity ^ s;
            if (cnt == '0) mode_r <= mode;
            if (mag < min1) begin
                min2 <= min1;
                min1 <= mag;
                idx1 <= cnt;
            end else if (mag < min2) begin
                min2 <= mag;
            end
        end else if (out_fire) begin
            cnt <= cnt + 1'b1;
        end
    end

    // extrinsic output built only from registers: exclude own edge, offset, then apply sign
    always_comb begin
        sel      = (cnt == idx1) ? min2 : min1;
        adj      = mode_r ? ((sel > OFF) ? sel - OFF : '0) : sel;
        out_data = out_valid ? ((parity ^ sgn[cnt]) ? -{1'b0, adj} : {1'b0, adj}) : '0;
        out_last = out_valid && at_last;
    end
endmodule

// File: tb/tb_minsum_check_node.sv
// tb_minsum_check_node: directed-vector bench for the min-sum check node
module tb_minsum_check_node;
    localparam int W = 21;
    localparam int DEG = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;

    int vecs = 0;
    int errs = 0;
    int vin[4];
    int vexp[4];

    minsum_check_node #(.W(W), .DEG(DEG), .OFFSET(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vecs++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sdata();
        return int'($signed(out_data));
    endfunction

    // mode is only meaningful on the first edge; later edges drive the opposite value
    task automatic send_block(input logic m, input bit gap);
        for (int i = 0; i < DEG; i++) begin
            if (gap && i == 2) begin
                in_valid = 1'b0;
                tick();
                check("pause_no_out", int'(out_valid), 0);
            end
            check("in_ready", int'(in_ready), 1);
            in_valid = 1'b1;
            in_data  = vin[i][W-1:0];
            mode     = (i == 0) ? m : ~m;
            tick();
        end
        in_valid = 1'b0;
        check("latency", int'(out_valid), 1);
    endtask

    task automatic recv_block(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < DEG; i++) begin
            int n = 0;
            while (!out_valid && n < 10) begin
                tick();
                n++;
            end
            check({tag, "_valid"}, int'(out_valid), 1);
            check({tag, "_data"}, sdata(), vexp[i]);
            check({tag, "_last"}, int'(out_last), (i == DEG - 1) ? 1 : 0);
            in_valid = 1'b1;
            in_data  = 21'h1;
            tick();
            in_valid = 1'b0;
        end
        out_ready = 1'b0;
        check({tag, "_back"}, int'(in_ready), 1);
        check({tag, "_idle"}, sdata(), 0);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", sdata(), 0);
        check("rst_out_last", int'(out_last), 0);
        rst_n = 1'b1;
        tick();

        vin = '{5, -3, 7, -2};         vexp = '{2, -2, 2, -3};
        send_block(1'b0, 1'b0);        recv_block("plain");
        vin = '{5, -3, 7, -2};         vexp = '{1, -1, 1, -2};
        send_block(1'b1, 1'b0);        recv_block("offset");
        vin = '{4, 4, -9, 6};          vexp = '{-4, -4, 4, -4};
        send_block(1'b0, 1'b1);        recv_block("tie");
        vin = '{0, -6, 3, 8};          vexp = '{-3, 0, 0, 0};
        send_block(1'b0, 1'b0);        recv_block("zero");
        vin = '{-1048576, 100, 200, 300}; vexp = '{100, -200, -100, -100};
        send_block(1'b0, 1'b0);        recv_block("sat");

        vin = '{5, -3, 7, -2};
        send_block(1'b0, 1'b0);
        check("bp_e0", sdata(), 2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold", sdata(), -2);
            check("bp_last", int'(out_last), 0);
        end
        rst_n = 1'b0;
        out_ready = 1'b1;
        tick();
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        out_ready = 1'b0;
        tick();

        vin = '{1, 1, 1, 1};           vexp = '{1, 1, 1, 1};
        send_block(1'b0, 1'b0);        recv_block("fresh");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
